// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: request sequencer for a 4-line fully associative, write-through,
// no-write-allocate cache with LRU replacement. Define CACHE_STATS_EN for hit/miss counters.
module cache_ctrl_fsm #(
   parameter int CACHE_SIZE = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic                  resp_hit,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [ADDR_WIDTH-1:0] lookup_addr,
   output logic [ADDR_WIDTH-1:0] tag_out_0,
   output logic [ADDR_WIDTH-1:0] tag_out_1,
   output logic [ADDR_WIDTH-1:0] tag_out_2,
   output logic [ADDR_WIDTH-1:0] tag_out_3,
   output logic                  valid_0,
   output logic                  valid_1,
   output logic                  valid_2,
   output logic                  valid_3,
   input  logic                  hit,
   input  logic [1:0]            hit_index,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]           stat_hits,
   output logic [15:0]           stat_misses
`endif
);

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;
   typedef logic [CACHE_SIZE-1:0][1:0] age_vec_t;

   state_t state_reg, state_next;

   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  we_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [ADDR_WIDTH-1:0] tag_reg  [CACHE_SIZE];
   logic [DATA_WIDTH-1:0] data_reg [CACHE_SIZE];
   logic [CACHE_SIZE-1:0] valid_reg;
   age_vec_t              age_reg;
   logic [1:0]            victim_reg, victim_next;
   logic                  resp_hit_reg;
   logic [DATA_WIDTH-1:0] resp_data_reg;

   // Ages stay a permutation of 0..3: lines younger than k shift up by one, k becomes 0.
   function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [1:0] k);
      age_vec_t result;
      result = ages;
      for (int i = 0; i < CACHE_SIZE; i++) begin
         if (ages[i] < ages[k]) result[i] = ages[i] + 2'd1;
      end
      result[k] = 2'd0;
      return result;
   endfunction

   // Lowest-index invalid line first, otherwise the oldest line.
   always_comb begin
      logic found;
      victim_next = 2'd0;
      found       = 1'b0;
      for (int i = 0; i < CACHE_SIZE; i++) begin
         if (!found && !valid_reg[i]) begin
            victim_next = 2'(i);
            found       = 1'b1;
         end
      end
      if (!found) begin
         for (int i = 0; i < CACHE_SIZE; i++) begin
            if (age_reg[i] == 2'd3) victim_next = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid) state_next = LOOKUP;
         LOOKUP:  state_next = we_reg ? WRITE : (hit ? RESP : FILL);
         FILL:    if (mem_ack) state_next = RESP;
         WRITE:   if (mem_ack) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_reg)
         IDLE:  req_ready = 1'b1;
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = addr_reg;
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_reg;
            mem_wdata = wdata_reg;
         end
         RESP:  resp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg      <= '0;
         we_reg        <= 1'b0;
         wdata_reg     <= '0;
         valid_reg     <= '0;
         victim_reg    <= 2'd0;
         resp_hit_reg  <= 1'b0;
         resp_data_reg <= '0;
         for (int i = 0; i < CACHE_SIZE; i++) begin
            tag_reg[i]  <= '0;
            data_reg[i] <= '0;
            age_reg[i]  <= 2'(i);
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  addr_reg  <= req_addr;
                  we_reg    <= req_we;
                  wdata_reg <= req_wdata;
               end
            end
            LOOKUP: begin
               resp_hit_reg <= hit;
               if (we_reg) begin
                  resp_data_reg <= '0;
                  if (hit) begin
                     data_reg[hit_index] <= wdata_reg;
                     age_reg             <= lru_touch(age_reg, hit_index);
                  end
               end else if (hit) begin
                  resp_data_reg <= data_reg[hit_index];
                  age_reg       <= lru_touch(age_reg, hit_index);
               end else begin
                  victim_reg <= victim_next;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  tag_reg[victim_reg]   <= addr_reg;
                  valid_reg[victim_reg] <= 1'b1;
                  data_reg[victim_reg]  <= mem_rdata;
                  resp_data_reg         <= mem_rdata;
                  resp_hit_reg          <= 1'b0;
                  age_reg               <= lru_touch(age_reg, victim_reg);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] stat_hits_reg, stat_misses_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hits_reg   <= '0;
         stat_misses_reg <= '0;
      end else if (state_reg == LOOKUP) begin
         if (hit) begin
            if (stat_hits_reg != 16'hFFFF) stat_hits_reg <= stat_hits_reg + 16'd1;
         end else begin
            if (stat_misses_reg != 16'hFFFF) stat_misses_reg <= stat_misses_reg + 16'd1;
         end
      end
   end

   assign stat_hits   = stat_hits_reg;
   assign stat_misses = stat_misses_reg;
`endif

   assign lookup_addr = addr_reg;
   assign resp_hit    = resp_hit_reg;
   assign resp_data   = resp_data_reg;
   assign tag_out_0   = tag_reg[0];
   assign tag_out_1   = tag_reg[1];
   assign tag_out_2   = tag_reg[2];
   assign tag_out_3   = tag_reg[3];
   assign valid_0     = valid_reg[0];
   assign valid_1     = valid_reg[1];
   assign valid_2     = valid_reg[2];
   assign valid_3     = valid_reg[3];

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Randomized bench for cache_ctrl_fsm: comparator and memory are modelled here, and
// expectations come from a recency-list cache model kept beside a flat memory image.
module tb_cache_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [7:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       resp_valid, resp_hit;
   logic [7:0] resp_data, lookup_addr;
   logic [7:0] tag_out_0, tag_out_1, tag_out_2, tag_out_3;
   logic       valid_0, valid_1, valid_2, valid_3;
   logic       hit;
   logic [1:0] hit_index;
   logic       mem_req, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [15:0] stat_hits, stat_misses;
`endif

   always #5 clk = ~clk;

   cache_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
      .lookup_addr(lookup_addr),
      .tag_out_0(tag_out_0), .tag_out_1(tag_out_1), .tag_out_2(tag_out_2), .tag_out_3(tag_out_3),
      .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
      .hit(hit), .hit_index(hit_index),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
   );

   logic [7:0] dut_tag [4];
   logic       dut_valid [4];
   assign dut_tag[0] = tag_out_0;
   assign dut_tag[1] = tag_out_1;
   assign dut_tag[2] = tag_out_2;
   assign dut_tag[3] = tag_out_3;
   assign dut_valid[0] = valid_0;
   assign dut_valid[1] = valid_1;
   assign dut_valid[2] = valid_2;
   assign dut_valid[3] = valid_3;

   // Parallel tag comparator environment.
   always_comb begin
      hit       = 1'b0;
      hit_index = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (dut_valid[i] && dut_tag[i] == lookup_addr) begin
            hit       = 1'b1;
            hit_index = 2'(i);
         end
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: memory image, line tags/valids, recency list (front = most recent).
   logic [7:0] mem_model [256];
   logic [7:0] m_tag [4];
   bit         m_valid [4];
   int         rec[$];
   int         m_hits, m_misses;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_tag[i]   = '0;
         m_valid[i] = 1'b0;
      end
      rec      = {0, 1, 2, 3};
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic model_touch(input int k);
      for (int j = 0; j < rec.size(); j++) begin
         if (rec[j] == k) begin
            rec.delete(j);
            break;
         end
      end
      rec.push_front(k);
   endtask

   task automatic check_lines(input string when);
      for (int i = 0; i < 4; i++) begin
         check_val({when, "_valid"}, 32'(dut_valid[i]), 32'(m_valid[i]));
         check_val({when, "_tag"}, 32'(dut_tag[i]), 32'(m_tag[i]));
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                         input int delay);
      int  mi, n, ack_n, mem_cycles, v;
      bit  exp_hit, got_resp;
      logic [7:0] exp_data;
      mi = -1;
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == addr) mi = i;
      exp_hit  = (mi >= 0);
      exp_data = we ? 8'h00 : mem_model[addr];

      @(negedge clk);
      check_val("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_wdata = 8'($urandom);

      n = 0; ack_n = -1; mem_cycles = 0; got_resp = 1'b0;
      while (!got_resp && n < 40) begin
         @(negedge clk);
         n++;
         mem_ack   = 1'b0;
         mem_rdata = 8'($urandom);
         if (n == 1) check_val("busy", 32'(req_ready), 32'd0);
         if (mem_req) begin
            if (mem_cycles == 0) begin
               check_val("mem_start", 32'(n), 32'd2);
               check_val("mem_we", 32'(mem_we), 32'(we));
               check_val("mem_addr", 32'(mem_addr), 32'(addr));
               check_val("mem_wdata", 32'(mem_wdata), we ? 32'(wd) : 32'd0);
            end
            mem_cycles++;
            if (mem_cycles > delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_model[addr];
               ack_n     = n;
            end
         end
         if (resp_valid) begin
            got_resp = 1'b1;
            check_val("resp_hit", 32'(resp_hit), 32'(exp_hit));
            check_val("resp_data", 32'(resp_data), 32'(exp_data));
            check_val("mem_idle", {mem_req, mem_we, 6'd0, mem_addr, mem_wdata}, 32'd0);
            if (!we && exp_hit) begin
               check_val("hit_latency", 32'(n), 32'd2);
               check_val("hit_no_mem", 32'(mem_cycles), 32'd0);
            end else begin
               check_val("mem_latency", 32'(n), 32'(ack_n + 1));
            end
         end
      end
      mem_ack = 1'b0;
      if (!got_resp) check_val("resp_timeout", 32'd0, 32'd1);

      if (exp_hit) m_hits++;
      else         m_misses++;
      if (we) begin
         mem_model[addr] = wd;
         if (exp_hit) model_touch(mi);
      end else if (exp_hit) begin
         model_touch(mi);
      end else begin
         v = -1;
         for (int i = 0; i < 4; i++) if (!m_valid[i] && v < 0) v = i;
         if (v < 0) v = rec[rec.size()-1];
         m_tag[v]   = addr;
         m_valid[v] = 1'b1;
         model_touch(v);
      end
      $display("req we=%0d addr=%02h wd=%02h hit=%0d data=%02h cycles=%0d",
               we, addr, wd, resp_hit, resp_data, n);
      @(negedge clk);
      check_val("idle_ready", 32'(req_ready), 32'd1);
      check_lines("lines");
   endtask

   initial begin
      logic [7:0] pool [6];
      for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
      mem_model[8'h10] = 8'hA5;
      model_reset();

      repeat (2) @(negedge clk);
      check_val("rst_ready", 32'(req_ready), 32'd1);
      check_val("rst_resp", {resp_valid, resp_hit, 22'd0, resp_data}, 32'd0);
      check_val("rst_mem", {mem_req, mem_we, 6'd0, mem_addr, mem_wdata}, 32'd0);
      check_val("rst_lookup", 32'(lookup_addr), 32'd0);
      check_lines("rst");
      rst_n = 1'b1;

      // Cold miss then hit on the same address.
      do_req(1'b0, 8'h10, 8'h00, 1);
      check_val("fill_tag0", 32'(tag_out_0), 32'h10);
      do_req(1'b0, 8'h10, 8'h00, 0);

      // LRU replacement: 8'h20 is oldest after touching 8'h10.
      do_reset();
      do_req(1'b0, 8'h10, 8'h00, 0);
      do_req(1'b0, 8'h20, 8'h00, 2);
      do_req(1'b0, 8'h30, 8'h00, 0);
      do_req(1'b0, 8'h40, 8'h00, 1);
      do_req(1'b0, 8'h10, 8'h00, 0);
      do_req(1'b0, 8'h50, 8'h00, 0);
      check_val("victim_tag1", 32'(tag_out_1), 32'h50);
      do_req(1'b0, 8'h10, 8'h00, 0);

      // Write-through hit, then write miss with no allocation.
      do_reset();
      do_req(1'b0, 8'h20, 8'h00, 0);
      do_req(1'b1, 8'h20, 8'h3C, 0);
      do_req(1'b0, 8'h20, 8'h00, 0);
      check_val("wr_hit_data", 32'(resp_data), 32'h3C);
      do_req(1'b1, 8'h99, 8'h5A, 2);

      // Reset during FILL, then a stray acknowledge.
      do_reset();
      do_req(1'b0, 8'h10, 8'h00, 0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_val("fill_req", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_drop_req", 32'(mem_req), 32'd0);
      check_val("rst_clr_valid", 32'(valid_0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (3) begin
         check_val("late_ack_resp", 32'(resp_valid), 32'd0);
         check_val("late_ack_req", 32'(mem_req), 32'd0);
         @(negedge clk);
      end
      check_lines("late_ack");

      // Random traffic over a small address pool so hits, misses and evictions mix.
      for (int i = 0; i < 6; i++) pool[i] = 8'($urandom);
      for (int t = 0; t < 250; t++) begin
         do_req(($urandom_range(0, 3) == 0), pool[$urandom_range(0, 5)],
                8'($urandom), int'($urandom_range(0, 3)));
      end

`ifdef CACHE_STATS_EN
      check_val("stat_hits", 32'(stat_hits), 32'(m_hits));
      check_val("stat_misses", 32'(stat_misses), 32'(m_misses));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
